// File: rtl/iot_sensor_pkg.sv
// Shared constants and types for the IoT sensor serial link.
// Holds clock/baud settings, UART frame width and receiver FSM states.
package iot_sensor_pkg;

  localparam int unsigned SYSTEM_CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD_RATE       = 115_200;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer for one asynchronous bit, reset value 1.
// Ports: clk, rst (async, active-high), i_async (raw), o_sync (synced).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/serial_receiver.sv
// 8N1 UART receiver with mid-bit sampling and valid/ack holding register.
// Ports: clk, rst (async, active-high), serial_rx (idle high) in;
//   rx_data, rx_valid, rx_busy, frame_err, overrun_err out; rx_ack in.
// Option: define SERIAL_RX_MAJORITY_EN for 2-of-3 vote at each sample point.
module serial_receiver
  import iot_sensor_pkg::*;
#(
  parameter int unsigned BAUD_DIV = SYSTEM_CLK_FREQ / BAUD_RATE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serial_rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ack,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      overrun_err
);

  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

  rx_state_e                 r_state;
  logic [15:0]               r_baud_cnt;
  logic [2:0]                r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_rx_data;
  logic                      r_rx_valid;
  logic                      r_frame_err;
  logic                      r_overrun_err;

  logic        w_rx_s;
  logic        w_bit;
  logic        w_at_tgt;
  logic [15:0] w_tgt;
  logic        w_done;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (serial_rx),
    .o_sync  (w_rx_s)
  );

  // Start bit is checked at half a bit, all later bits at full bit.
  assign w_tgt    = (r_state == RX_START) ? HALF_LAST : DIV_LAST;
  assign w_at_tgt = (r_baud_cnt == w_tgt);

`ifdef SERIAL_RX_MAJORITY_EN
  // Counter runs contiguously before each target, so the last two
  // cycles of rx_s are exactly the target-2 and target-1 samples.
  logic [1:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_bit = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  assign w_done = (r_state == RX_STOP) && w_at_tgt && w_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!w_rx_s) begin
            r_state    <= RX_START;
            r_baud_cnt <= '0;
          end
        end
        RX_START: begin
          if (w_at_tgt) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= w_bit ? RX_IDLE : RX_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_at_tgt) begin
            r_baud_cnt <= '0;
            r_shift    <= {w_bit, r_shift[UART_DATA_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_at_tgt) begin
            r_baud_cnt <= '0;
            if (w_bit) begin
              r_state <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= RX_BREAK;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        RX_BREAK: begin
          if (w_rx_s) begin
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_state    <= RX_IDLE;
          r_baud_cnt <= '0;
        end
      endcase
    end
  end

  // A new byte wins over a same-cycle ack; overrun only if unacked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_overrun_err <= 1'b0;
      if (w_done) begin
        r_rx_data     <= r_shift;
        r_rx_valid    <= 1'b1;
        r_overrun_err <= r_rx_valid && !rx_ack;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_busy     = (r_state != RX_IDLE);
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver at BAUD_DIV=16.
// Frame-level model predicts outputs; directed frames drive the line.
module tb_serial_receiver;

  localparam int unsigned BD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  serial_receiver #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_rx   (serial_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Frame-level expectations: load/error edges and busy windows.
  int unsigned ld_cyc[$];
  logic [7:0]  ld_dat[$];
  int unsigned fe_cyc[$];
  int unsigned bs[$];
  int unsigned be[$];

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ferr;
  logic       m_ovr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      logic       ld;
      logic       fe;
      logic [7:0] d;
      ld = 1'b0;
      fe = 1'b0;
      d  = m_data;
      foreach (ld_cyc[i]) if (ld_cyc[i] == cyc + 1) begin
        ld = 1'b1;
        d  = ld_dat[i];
      end
      foreach (fe_cyc[i]) if (fe_cyc[i] == cyc + 1) fe = 1'b1;
      m_ferr <= fe;
      m_ovr  <= ld && m_valid && !rx_ack;
      if (ld) begin
        m_valid <= 1'b1;
        m_data  <= d;
      end else if (rx_ack) begin
        m_valid <= 1'b0;
      end
    end
  end

  function automatic logic exp_busy(input int unsigned n);
    foreach (bs[i]) if (bs[i] <= n && n <= be[i]) return 1'b1;
    return 1'b0;
  endfunction

  logic        armed = 1'b0;
  logic        pv = 1'b0;
  int          rise_cnt = 0;
  int unsigned last_rise = 0;
  int          busy_cnt = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("rx_valid", rx_valid, m_valid);
      check("rx_data", rx_data, m_data);
      check("frame_err", frame_err, m_ferr);
      check("overrun_err", overrun_err, m_ovr);
      check("rx_busy", rx_busy, exp_busy(cyc));
      if (rx_valid && !pv) begin
        rise_cnt++;
        last_rise = cyc;
      end
      pv = rx_valid;
      if (rx_busy) busy_cnt++;
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
    end
  end

  logic auto_ack = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (auto_ack) rx_ack = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned last_p;

  // Drives one 160-cycle frame; the line falls right after edge p.
  task automatic send(input logic [7:0] d, input bit stop,
                      input bit spike, input bit ack_done,
                      input int hold);
    int unsigned p;
    logic v;
    logic [7:0] ed;
    tick();
    p = cyc;
    last_p = p;
`ifdef SERIAL_RX_MAJORITY_EN
    ed = d;
`else
    ed = spike ? ~d : d;
`endif
    bs.push_back(p + 3);
    if (stop) begin
      be.push_back(p + 154);
      ld_cyc.push_back(p + 155);
      ld_dat.push_back(ed);
    end else begin
      be.push_back(32'hFFFF_FFFF);
      fe_cyc.push_back(p + 155);
    end
    for (int k = 0; k < 10 * BD; k++) begin
      int b;
      b = k / BD;
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else v = stop;
      if (spike && b >= 1 && b <= 8 && (k % BD) == 8) v = ~v;
      serial_rx = v;
      if (ack_done && k == 154) rx_ack = 1'b1;
      if (ack_done && k == 155) rx_ack = 1'b0;
      tick();
    end
    if (!stop) begin
      repeat (hold) tick();
      check("busy_in_break", rx_busy, 1);
      serial_rx = 1'b1;
      be[be.size()-1] = cyc + 2;
      repeat (8) tick();
    end
    serial_rx = 1'b1;
  endtask

  task automatic ack_now();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    tick();
  endtask

  int r0, b0, f0, o0;
  int unsigned r;

  initial begin
    rst = 1'b1;
    serial_rx = 1'b1;
    rx_ack = 1'b0;
    repeat (3) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", rx_busy, 0);
    check("rst_errs", {frame_err, overrun_err}, 0);
    rst = 1'b0;
    armed = 1'b1;
    repeat (5) tick();

    send(8'hA5, 1, 0, 0, 0);
    check("a5_latency", last_rise - last_p, 155);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 1);
    ack_now();
    check("a5_acked", rx_valid, 0);

    r0 = rise_cnt;
    o0 = ov_cnt;
    f0 = fe_cnt;
    auto_ack = 1'b1;
    send(8'h00, 1, 0, 0, 0);
    send(8'hFF, 1, 0, 0, 0);
    send(8'h55, 1, 0, 0, 0);
    repeat (4) tick();
    auto_ack = 1'b0;
    rx_ack = 1'b0;
    check("loop_rises", rise_cnt - r0, 3);
    check("loop_last", rx_data, 8'h55);
    check("loop_errs", (ov_cnt - o0) + (fe_cnt - f0), 0);

    r0 = rise_cnt;
    b0 = busy_cnt;
    tick();
    serial_rx = 1'b0;
    bs.push_back(cyc + 3);
    be.push_back(cyc + 10);
    repeat (4) tick();
    serial_rx = 1'b1;
    repeat (20) tick();
    check("glitch_busy", busy_cnt - b0, 8);
    check("glitch_valid", rise_cnt - r0, 0);

    f0 = fe_cnt;
    send(8'h3C, 0, 0, 0, 24);
    check("break_ferr", fe_cnt - f0, 1);
    check("break_valid", rx_valid, 0);
    check("break_busy", rx_busy, 0);
    send(8'h81, 1, 0, 0, 0);
    check("after_break", rx_data, 8'h81);
    ack_now();

    o0 = ov_cnt;
    send(8'h11, 1, 0, 0, 0);
    send(8'h22, 1, 0, 0, 0);
    check("ovr_pulse", ov_cnt - o0, 1);
    check("ovr_data", rx_data, 8'h22);
    send(8'h33, 1, 0, 1, 0);
    check("ack_same", ov_cnt - o0, 1);
    check("ack_same_data", rx_data, 8'h33);
    check("ack_same_valid", rx_valid, 1);

    tick();
    r = cyc;
    serial_rx = 1'b0;
    bs.push_back(r + 3);
    be.push_back(32'hFFFF_FFFF);
    for (int k = 0; k < BD * 5 + 8; k++) begin
      int b;
      logic [7:0] pat;
      pat = 8'h99;
      b = k / BD;
      serial_rx = (b == 0) ? 1'b0 : pat[b-1];
      tick();
    end
    r = cyc;
    rst = 1'b1;
    serial_rx = 1'b1;
    be[be.size()-1] = r - 1;
    ld_cyc.delete();
    ld_dat.delete();
    fe_cyc.delete();
    #1;
    check("mid_rst", {rx_valid, rx_busy, frame_err, overrun_err}, 0);
    check("mid_rst_data", rx_data, 8'h00);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    send(8'h7E, 1, 0, 0, 0);
    check("after_rst", rx_data, 8'h7E);
    ack_now();

    send(8'hC3, 1, 1, 0, 0);
`ifdef SERIAL_RX_MAJORITY_EN
    check("spike_c3", rx_data, 8'hC3);
`else
    check("spike_c3", rx_data, 8'h3C);
`endif
    ack_now();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
